// File: rtl/riscv_core_completion_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_completion_arbiter
// Description : Merges three completion sources into two ROB finish ports,
//               spilling excess completions into a 4-entry in-order queue.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_core_completion_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmpl_val_0,
    input  logic [4:0] cmpl_slot_0,
    input  logic       cmpl_val_1,
    input  logic [4:0] cmpl_slot_1,
    input  logic       cmpl_val_2,
    input  logic [4:0] cmpl_slot_2,
    output logic       cmpl_rdy_2,
    output logic       ROB_commit_req_A,
    output logic [4:0] ROB_commit_req_slot_A,
    output logic       ROB_commit_req_B,
    output logic [4:0] ROB_commit_req_slot_B,
    output logic [2:0] cmpl_q_count
);

    localparam logic [2:0] c_DEPTH = 3'd4;

    logic [1:0] head_q, head_d;
    logic [1:0] tail_q, tail_d;
    logic [2:0] count_q, count_d;
    logic [4:0] mem_q [4];
    logic [4:0] mem_d [4];

    logic [4:0] w_cand_val;
    logic [4:0] w_cand_slot [5];
    logic [2:0] w_n;
    logic [2:0] w_push;
    logic [2:0] w_pop;

    // src2 may only be taken while the queue has room; depends on state only.
    assign cmpl_rdy_2   = !reset && (count_q < c_DEPTH);
    assign cmpl_q_count = reset ? 3'd0 : count_q;

    always_comb begin
        w_cand_val[0]  = !reset && (count_q >= 3'd1);
        w_cand_slot[0] = mem_q[head_q];
        w_cand_val[1]  = !reset && (count_q >= 3'd2);
        w_cand_slot[1] = mem_q[head_q + 2'd1];
        w_cand_val[2]  = !reset && cmpl_val_0;
        w_cand_slot[2] = cmpl_slot_0;
        w_cand_val[3]  = !reset && cmpl_val_1;
        w_cand_slot[3] = cmpl_slot_1;
        w_cand_val[4]  = cmpl_val_2 && cmpl_rdy_2;
        w_cand_slot[4] = cmpl_slot_2;
    end

    always_comb begin
        ROB_commit_req_A      = 1'b0;
        ROB_commit_req_slot_A = 5'd0;
        ROB_commit_req_B      = 1'b0;
        ROB_commit_req_slot_B = 5'd0;
        mem_d                 = mem_q;
        w_n                   = 3'd0;
        // First two candidates go to the ports, the rest spill in list order.
        for (int i = 0; i < 5; i++) begin
            if (w_cand_val[i]) begin
                if (w_n == 3'd0) begin
                    ROB_commit_req_A      = 1'b1;
                    ROB_commit_req_slot_A = w_cand_slot[i];
                end else if (w_n == 3'd1) begin
                    ROB_commit_req_B      = 1'b1;
                    ROB_commit_req_slot_B = w_cand_slot[i];
                end else begin
                    mem_d[tail_q + 2'(w_n - 3'd2)] = w_cand_slot[i];
                end
                w_n = w_n + 3'd1;
            end
        end
        w_push  = (w_n > 3'd2) ? (w_n - 3'd2) : 3'd0;
        w_pop   = {2'b00, w_cand_val[0]} + {2'b00, w_cand_val[1]};
        count_d = count_q + w_push - w_pop;
        head_d  = head_q + w_pop[1:0];
        tail_d  = tail_q + w_push[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read below the valid count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !((count_q == c_DEPTH) && (w_push > w_pop)));

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_completion_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_core_completion_arbiter
// Description : Directed vector table, corner sequences and a random run
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_core_completion_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       v0, v1, v2;
    logic [4:0] s0, s1, s2;
    logic       rdy2, req_a, req_b;
    logic [4:0] slot_a, slot_b;
    logic [2:0] qcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_core_completion_arbiter dut (
        .clk                   (clk),
        .reset                 (reset),
        .cmpl_val_0            (v0),
        .cmpl_slot_0           (s0),
        .cmpl_val_1            (v1),
        .cmpl_slot_1           (s1),
        .cmpl_val_2            (v2),
        .cmpl_slot_2           (s2),
        .cmpl_rdy_2            (rdy2),
        .ROB_commit_req_A      (req_a),
        .ROB_commit_req_slot_A (slot_a),
        .ROB_commit_req_B      (req_b),
        .ROB_commit_req_slot_B (slot_b),
        .cmpl_q_count          (qcnt)
    );

    typedef struct {
        logic       rst;
        logic       v0;
        logic [4:0] s0;
        logic       v1;
        logic [4:0] s1;
        logic       v2;
        logic [4:0] s2;
        logic       ea;
        logic [4:0] esa;
        logic       eb;
        logic [4:0] esb;
        logic       erdy;
        logic [2:0] ecnt;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] mq[$];
    logic [4:0] sb[$];
    logic [4:0] cand[$];

    function automatic vec_t mk(logic r, logic a0, logic [4:0] b0, logic a1, logic [4:0] b1,
                                logic a2, logic [4:0] b2, logic ea, logic [4:0] esa,
                                logic eb, logic [4:0] esb, logic erdy, logic [2:0] ecnt);
        vec_t v;
        v.rst = r;  v.v0 = a0; v.s0 = b0; v.v1 = a1; v.s1 = b1; v.v2 = a2; v.s2 = b2;
        v.ea = ea;  v.esa = esa; v.eb = eb; v.esb = esb; v.erdy = erdy; v.ecnt = ecnt;
        return v;
    endfunction

    function automatic logic [15:0] pk(logic a, logic [4:0] sa, logic b, logic [4:0] sbv,
                                       logic rdy, logic [2:0] cnt);
        return {a, sa, b, sbv, rdy, cnt};
    endfunction

    function automatic string fmt(logic [15:0] o);
        return $sformatf("A=%0b/%0d B=%0b/%0d rdy2=%0b count=%0d",
                         o[15], o[14:10], o[9], o[8:4], o[3], o[2:0]);
    endfunction

    task automatic check_out(input string name, input logic [15:0] exp);
        logic [15:0] act;
        act = pk(req_a, slot_a, req_b, slot_b, rdy2, qcnt);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %s, required %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic a0, input logic [4:0] b0, input logic a1,
                          input logic [4:0] b1, input logic a2, input logic [4:0] b2);
        reset = r; v0 = a0; s0 = b0; v1 = a1; s1 = b1; v2 = a2; s2 = b2;
    endtask

    task automatic step_and_check(input string name, input logic [15:0] exp);
        @(negedge clk);
        check_out(name, exp);
        @(posedge clk);
        #1;
    endtask

    // One cycle against the reference model: queue head entries first, then
    // this cycle's arrivals; the first two are reported, the rest are queued.
    task automatic model_cycle(input string tag, input logic a0, input logic [4:0] b0,
                               input logic a1, input logic [4:0] b1,
                               input logic a2, input logic [4:0] b2);
        logic       erdy;
        logic [4:0] exp_slot;
        int         npop;
        set_in(1'b0, a0, b0, a1, b1, a2, b2);
        cand.delete();
        for (int i = 0; i < 2 && i < mq.size(); i++) cand.push_back(mq[i]);
        erdy = (mq.size() < 4);
        if (a0)         begin cand.push_back(b0); sb.push_back(b0); end
        if (a1)         begin cand.push_back(b1); sb.push_back(b1); end
        if (a2 && erdy) begin cand.push_back(b2); sb.push_back(b2); end
        @(negedge clk);
        check_out({tag, "_outputs"}, pk(cand.size() > 0, (cand.size() > 0) ? cand[0] : 5'd0,
                                        cand.size() > 1, (cand.size() > 1) ? cand[1] : 5'd0,
                                        erdy, 3'(mq.size())));
        check_int({tag, "_b_without_a"}, int'(req_b && !req_a), 0);
        if (req_a) begin
            exp_slot = (sb.size() > 0) ? sb.pop_front() : 5'd0;
            check_int({tag, "_order_a"}, int'(slot_a), int'(exp_slot));
        end
        if (req_b) begin
            exp_slot = (sb.size() > 0) ? sb.pop_front() : 5'd0;
            check_int({tag, "_order_b"}, int'(slot_b), int'(exp_slot));
        end
        npop = (mq.size() < 2) ? mq.size() : 2;
        repeat (npop) void'(mq.pop_front());
        for (int i = 2; i < cand.size(); i++) mq.push_back(cand[i]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] pend;
        logic [4:0] sa, sbs;

        set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        #1;

        vecs.push_back(mk(1, 1,  1, 1,  2, 1,  3, 0,  0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 1,  3, 1,  4, 0,  0, 1,  3, 1,  4, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 1,  5, 1,  6, 1,  7, 1,  5, 1,  6, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 1,  7, 0,  0, 1, 1));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 1,  8, 1,  9, 1, 10, 1,  8, 1,  9, 1, 0));
        vecs.push_back(mk(0, 1, 11, 1, 12, 1, 13, 1, 10, 1, 11, 1, 1));
        vecs.push_back(mk(0, 1, 14, 1, 15, 1, 16, 1, 12, 1, 13, 1, 2));
        vecs.push_back(mk(0, 1, 17, 1, 18, 1, 19, 1, 14, 1, 15, 1, 3));
        vecs.push_back(mk(0, 1, 20, 1, 21, 1, 30, 1, 16, 1, 17, 0, 4));
        vecs.push_back(mk(0, 1, 22, 1, 23, 1, 30, 1, 18, 1, 19, 0, 4));
        vecs.push_back(mk(0, 1, 24, 1, 25, 1, 30, 1, 20, 1, 21, 0, 4));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 1, 22, 1, 23, 0, 4));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 1, 24, 1, 25, 1, 2));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 1,  9, 0,  0, 1, 11, 1,  9, 1, 11, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 12, 1, 13, 1, 12, 1, 13, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 1, 14, 1, 14, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 31, 0,  0, 1, 31, 0,  0, 1, 0));
        vecs.push_back(mk(0, 1,  0, 0,  0, 0,  0, 1,  0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 0));

        foreach (vecs[i]) begin
            set_in(vecs[i].rst, vecs[i].v0, vecs[i].s0, vecs[i].v1, vecs[i].s1,
                   vecs[i].v2, vecs[i].s2);
            step_and_check($sformatf("vec%0d", i),
                           pk(vecs[i].ea, vecs[i].esa, vecs[i].eb, vecs[i].esb,
                              vecs[i].erdy, vecs[i].ecnt));
        end

        // Wrap-around: hold one queued entry, push one and pop one per cycle.
        set_in(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
        step_and_check("wrap_prime", pk(1, 1, 1, 2, 1, 0));
        pend = 5'd3;
        for (int k = 0; k < 10; k++) begin
            sa  = 5'(4 + 2 * k);
            sbs = 5'(5 + 2 * k);
            set_in(1'b0, 1'b1, sa, 1'b1, sbs, 1'b0, 5'd0);
            step_and_check($sformatf("wrap%0d", k), pk(1, pend, 1, sa, 1, 1));
            pend = sbs;
        end
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step_and_check("wrap_drain", pk(1, pend, 0, 0, 1, 1));
        step_and_check("wrap_empty", pk(0, 0, 0, 0, 1, 0));

        // Reset while three entries are queued and all sources are valid.
        set_in(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
        step_and_check("rst_fill0", pk(1, 1, 1, 2, 1, 0));
        set_in(1'b0, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6);
        step_and_check("rst_fill1", pk(1, 3, 1, 4, 1, 1));
        set_in(1'b0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd9);
        step_and_check("rst_fill2", pk(1, 5, 1, 6, 1, 2));
        set_in(1'b1, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd12);
        step_and_check("rst_during", pk(0, 0, 0, 0, 0, 0));
        set_in(1'b0, 1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0);
        step_and_check("rst_after", pk(1, 13, 0, 0, 1, 0));
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step_and_check("rst_no_stale", pk(0, 0, 0, 0, 1, 0));

        mq.delete();
        sb.delete();
        for (int c = 0; c < 10000; c++) begin
            model_cycle("rand",
                        $urandom_range(0, 99) < 75, 5'($urandom_range(0, 31)),
                        $urandom_range(0, 99) < 75, 5'($urandom_range(0, 31)),
                        $urandom_range(0, 99) < 70, 5'($urandom_range(0, 31)));
        end
        for (int c = 0; c < 4; c++) begin
            model_cycle("drain", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        end
        check_int("all_reported", sb.size(), 0);
        @(negedge clk);
        check_int("final_count", int'(qcnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
